// File: rtl/sram_frame_loader_if.sv
// Pixel stream and SRAM write bus between the frame source and sram_frame_loader.
// The master side is the source of getNext and pixel bytes. The slave side is the loader,
// which drives the SRAM write port and the status pulses.
interface sram_frame_loader_if #(
  parameter int ADDR_W = 20
);
  logic              getNext;
  logic [7:0]        pixIn;
  logic              pixValid;
  logic              pixReady;
  logic              we1;
  logic [ADDR_W-1:0] write_addr1;
  logic [63:0]       data1;
  logic              startEn;
  logic              busy;

  modport master (
    output getNext, pixIn, pixValid,
    input  pixReady, we1, write_addr1, data1, startEn, busy
  );

  modport slave (
    input  getNext, pixIn, pixValid,
    output pixReady, we1, write_addr1, data1, startEn, busy
  );
endinterface

// File: rtl/sram_frame_loader.sv
// Write side of the SRAM1 image buffer.
// Packs a raster byte stream into 64-bit little-endian words and writes them to consecutive
// SRAM word addresses. After the last word of the frame has been written, it pulses startEn.
// A request that arrives while a frame is loading is held in a one-deep pending flag.
module sram_frame_loader #(
  parameter int FRAME_WORDS = 32768,
  parameter int BASE_ADDR   = 0,
  parameter int ADDR_W      = 20
) (
  input  logic               clk,
  input  logic               reset,
  sram_frame_loader_if.slave bus
);

  localparam int CNT_W = $clog2(FRAME_WORDS + 1);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(FRAME_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        byteIdx_q, byteIdx_d;
  logic [CNT_W-1:0]  wordIdx_q, wordIdx_d;
  logic [55:0]       shift_q, shift_d;
  logic              pending_q, pending_d;
  logic              lastWord_q, lastWord_d;
  logic              we1_q, we1_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       data_q, data_d;
  logic              xfer;

  // A byte moves only in LOAD, and only before the final word has been committed.
  assign bus.pixReady    = (state_q == LOAD) && !lastWord_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.startEn     = (state_q == DONE);
  assign bus.we1         = we1_q;
  assign bus.write_addr1 = addr_q;
  assign bus.data1       = data_q;
  assign xfer            = bus.pixReady && bus.pixValid;

  // Next-state logic: request handling, byte packing, word commit and frame completion.
  always_comb begin
    state_d    = state_q;
    byteIdx_d  = byteIdx_q;
    wordIdx_d  = wordIdx_q;
    shift_d    = shift_q;
    pending_d  = pending_q;
    lastWord_d = lastWord_q;
    we1_d      = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;

    case (state_q)
      IDLE: begin
        if (bus.getNext || pending_q) begin
          state_d    = LOAD;
          byteIdx_d  = 3'd0;
          wordIdx_d  = '0;
          pending_d  = 1'b0;
          lastWord_d = 1'b0;
        end
      end

      LOAD: begin
        pending_d = pending_q || bus.getNext;
        if (lastWord_q) begin
          // This is the cycle in which the final we1 pulse is high. Finish after it.
          state_d    = DONE;
          lastWord_d = 1'b0;
        end else if (xfer) begin
          if (byteIdx_q == 3'd7) begin
            data_d    = {bus.pixIn, shift_q};
            addr_d    = BASE + ADDR_W'(wordIdx_q);
            we1_d     = 1'b1;
            wordIdx_d = wordIdx_q + 1'b1;
            byteIdx_d = 3'd0;
            if (wordIdx_q == LAST_WORD) begin
              lastWord_d = 1'b1;
            end
          end else begin
            for (int k = 0; k < 7; k++) begin
              if (byteIdx_q == 3'(k)) begin
                shift_d[8*k +: 8] = bus.pixIn;
              end
            end
            byteIdx_d = byteIdx_q + 3'd1;
          end
        end
      end

      DONE: begin
        pending_d = pending_q || bus.getNext;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any partial word and any pending request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      byteIdx_q  <= 3'd0;
      wordIdx_q  <= '0;
      shift_q    <= '0;
      pending_q  <= 1'b0;
      lastWord_q <= 1'b0;
      we1_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      byteIdx_q  <= byteIdx_d;
      wordIdx_q  <= wordIdx_d;
      shift_q    <= shift_d;
      pending_q  <= pending_d;
      lastWord_q <= lastWord_d;
      we1_q      <= we1_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: tb/tb_sram_frame_loader.sv
// Testbench for sram_frame_loader with a 4-word frame based at word address 16.
// Expected SRAM writes are queued as frames are driven and are popped as we1 pulses appear.
module tb_sram_frame_loader;

  localparam int FRAME_WORDS = 4;
  localparam int BASE_ADDR   = 16;
  localparam int ADDR_W      = 20;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [63:0]       data;
  } expWrite_t;

  typedef struct {
    logic [7:0] firstByte;
    bit         gapped;
    int         weSpacing;
  } frameVec_t;

  logic clk;
  logic reset;
  int   cyc;
  int   errors;
  int   checks;

  expWrite_t sb[$];
  int        weCycles[$];
  int        startCycles[$];

  sram_frame_loader_if #(.ADDR_W(ADDR_W)) bus ();

  sram_frame_loader #(
    .FRAME_WORDS(FRAME_WORDS),
    .BASE_ADDR  (BASE_ADDR),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to time we1 and startEn pulses
  always @(posedge clk) cyc <= cyc + 1;

  // Compare one observed value with its expected value and log any miss
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every we1 pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (bus.we1) begin
        weCycles.push_back(cyc);
        if (sb.size() == 0) begin
          checkOutput("unexpectedWrite", 64'd1, 64'd0);
        end else begin
          expWrite_t e;
          e = sb.pop_front();
          checkOutput("writeAddr", 64'(bus.write_addr1), 64'(e.addr));
          checkOutput("writeData", bus.data1, e.data);
        end
      end
      if (bus.startEn) startCycles.push_back(cyc);
    end
  end

  function automatic logic [63:0] packWord(input logic [7:0] first, input int w);
    logic [63:0] v;
    logic [7:0]  b;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      b = first + 8'(8 * w + k);
      v[8*k +: 8] = b;
    end
    return v;
  endfunction

  task automatic pushFrame(input logic [7:0] first);
    for (int w = 0; w < FRAME_WORDS; w++) begin
      expWrite_t e;
      e.addr = ADDR_W'(BASE_ADDR + w);
      e.data = packWord(first, w);
      sb.push_back(e);
    end
  endtask

  task automatic pulseGetNext;
    @(negedge clk);
    #1 bus.getNext = 1'b1;
    @(negedge clk);
    #1 bus.getNext = 1'b0;
  endtask

  // Drive n bytes from first upward, counting those accepted by the handshake
  task automatic applyStimulus(input logic [7:0] first, input int n, input bit gapped,
                               input int budget, output int accepted);
    int  idx;
    int  c;
    bit  tog;
    bit  valid;
    bit  ready;
    idx = 0;
    c   = 0;
    tog = 1'b1;
    while (idx < n && c < budget) begin
      valid        = gapped ? tog : 1'b1;
      bus.pixValid = valid;
      bus.pixIn    = first + 8'(idx);
      ready        = bus.pixReady;
      @(posedge clk);
      if (valid && ready) idx++;
      @(negedge clk);
      #1;
      tog = !tog;
      c++;
    end
    bus.pixValid = 1'b0;
    accepted = idx;
  endtask

  task automatic waitStartEn(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (bus.startEn) seen = 1'b1;
    end
    checkOutput(name, 64'(seen), 64'd1);
  endtask

  task automatic clearRecords;
    sb.delete();
    weCycles.delete();
    startCycles.delete();
  endtask

  // Run one complete frame and check its write timing against the expected spacing
  task automatic runFrame(input frameVec_t v, input string tag);
    int acc;
    clearRecords();
    pushFrame(v.firstByte);
    pulseGetNext();
    applyStimulus(v.firstByte, 32, v.gapped, 400, acc);
    checkOutput({tag, "_accepted"}, 64'(acc), 64'd32);
    waitStartEn(10, {tag, "_startEn"});
    checkOutput({tag, "_weCount"}, 64'(weCycles.size()), 64'(FRAME_WORDS));
    checkOutput({tag, "_sbEmpty"}, 64'(sb.size()), 64'd0);
    if (weCycles.size() == FRAME_WORDS && startCycles.size() == 1) begin
      for (int w = 1; w < FRAME_WORDS; w++) begin
        checkOutput({tag, "_weSpacing"}, 64'(weCycles[w] - weCycles[w-1]), 64'(v.weSpacing));
      end
      checkOutput({tag, "_startAfterWe"}, 64'(startCycles[0] - weCycles[FRAME_WORDS-1]), 64'd1);
    end else begin
      checkOutput({tag, "_startCount"}, 64'(startCycles.size()), 64'd1);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    frameVec_t vecs[3];
    int acc;

    errors = 0;
    checks = 0;
    cyc    = 0;
    bus.getNext  = 1'b0;
    bus.pixValid = 1'b0;
    bus.pixIn    = 8'h00;
    reset        = 1'b0;

    vecs[0] = '{firstByte: 8'h00, gapped: 1'b0, weSpacing: 8};
    vecs[1] = '{firstByte: 8'h00, gapped: 1'b1, weSpacing: 16};
    vecs[2] = '{firstByte: 8'h5A, gapped: 1'b0, weSpacing: 8};

    // Reset, then idle: every output must stay low
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("idle_we1",      64'(bus.we1),         64'd0);
    checkOutput("idle_addr",     64'(bus.write_addr1), 64'd0);
    checkOutput("idle_data",     bus.data1,            64'd0);
    checkOutput("idle_startEn",  64'(bus.startEn),     64'd0);
    checkOutput("idle_busy",     64'(bus.busy),        64'd0);
    checkOutput("idle_pixReady", 64'(bus.pixReady),    64'd0);

    // Table-driven frames: back-to-back, gapped, different byte values
    for (int i = 0; i < 3; i++) begin
      runFrame(vecs[i], $sformatf("frame%0d", i));
    end

    // getNext during LOAD is held pending and restarts after an IDLE pass-through
    clearRecords();
    pushFrame(8'h00);
    pushFrame(8'h20);
    pulseGetNext();
    fork
      applyStimulus(8'h00, 32, 1'b0, 200, acc);
      begin
        repeat (10) @(negedge clk);
        #2 bus.getNext = 1'b1;
        @(negedge clk);
        #2 bus.getNext = 1'b0;
      end
    join
    checkOutput("pend_accepted1", 64'(acc), 64'd32);
    waitStartEn(10, "pend_startEn1");
    @(negedge clk);
    #1;
    checkOutput("pend_idlePass", 64'(bus.busy), 64'd0);
    @(negedge clk);
    #1;
    checkOutput("pend_busyAgain", 64'(bus.busy), 64'd1);
    applyStimulus(8'h20, 32, 1'b0, 200, acc);
    checkOutput("pend_accepted2", 64'(acc), 64'd32);
    waitStartEn(10, "pend_startEn2");
    checkOutput("pend_sbEmpty", 64'(sb.size()), 64'd0);
    checkOutput("pend_startCount", 64'(startCycles.size()), 64'd2);
    repeat (3) @(negedge clk);
    checkOutput("pend_noThird", 64'(bus.busy), 64'd0);

    // Reset after 13 bytes: only the first word is written, then everything clears at once
    clearRecords();
    pushFrame(8'h00);
    while (sb.size() > 1) void'(sb.pop_back());
    pulseGetNext();
    applyStimulus(8'h00, 13, 1'b0, 100, acc);
    reset = 1'b0;
    #1;
    checkOutput("rst_we1",      64'(bus.we1),         64'd0);
    checkOutput("rst_addr",     64'(bus.write_addr1), 64'd0);
    checkOutput("rst_data",     bus.data1,            64'd0);
    checkOutput("rst_busy",     64'(bus.busy),        64'd0);
    checkOutput("rst_pixReady", 64'(bus.pixReady),    64'd0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rst_noStartEn", 64'(startCycles.size()), 64'd0);
    checkOutput("rst_oneWord",   64'(weCycles.size()),    64'd1);
    runFrame('{firstByte: 8'h80, gapped: 1'b0, weSpacing: 8}, "restart");

    // pixValid held past the frame end: exactly 32 bytes are taken
    clearRecords();
    pushFrame(8'h40);
    pulseGetNext();
    applyStimulus(8'h40, 40, 1'b0, 60, acc);
    checkOutput("over_accepted", 64'(acc), 64'd32);
    checkOutput("over_pixReady", 64'(bus.pixReady), 64'd0);
    checkOutput("over_weCount",  64'(weCycles.size()), 64'(FRAME_WORDS));
    checkOutput("over_startEn",  64'(startCycles.size()), 64'd1);
    checkOutput("over_sbEmpty",  64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
